// File: rtl/noc_packet_injector.sv
// ---------------------------------------------------------------------------
// noc_packet_injector
//
// Purpose:
//   Network-interface transmitter at the source end of the router input-port
//   req/ack flit protocol. A whole packet of payload words is collected from
//   the local core into an internal store first. The injector then performs
//   the start handshake and streams the packet as one gap-free burst: header,
//   body..., tail. Storing first is necessary because the receiving buffer
//   writes one flit every cycle once the burst has started and cannot stall.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous, active-high reset
//   i_src_valid  in   local payload word valid
//   o_src_ready  out  word accepted when i_src_valid & o_src_ready
//   i_src_data   in   payload word (DATA_WIDTH-2 bits)
//   i_src_last   in   last word of the packet
//   i_src_dest   in   destination, taken from the first word of a packet
//   o_tx_req     out  start-of-packet request to the router input port
//   i_tx_ack     in   acknowledge from the router input port
//   o_tx_data    out  flit bus, {type[1:0], payload}
//   o_pkt_sent   out  one-cycle pulse in the cycle after the tail flit
//   o_truncated  out  one-cycle pulse when a packet is cut at max length
// ---------------------------------------------------------------------------

`ifndef FLIT_HEADER
`define FLIT_HEADER 2'b01
`endif
`ifndef FLIT_BODY
`define FLIT_BODY 2'b10
`endif
`ifndef FLIT_TAIL
`define FLIT_TAIL 2'b11
`endif

module noc_packet_injector #(
    parameter int DATA_WIDTH      = 18,
    parameter int MAX_PACKET_SIZE = 64,
    parameter int ADDRESS_SIZE    = 4,
    parameter int LOCAL_ADDR      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_src_valid,
    output logic                    o_src_ready,
    input  logic [DATA_WIDTH-3:0]   i_src_data,
    input  logic                    i_src_last,
    input  logic [ADDRESS_SIZE-1:0] i_src_dest,
    output logic                    o_tx_req,
    input  logic                    i_tx_ack,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_pkt_sent,
    output logic                    o_truncated
);

    localparam int PAYLOAD_WIDTH = DATA_WIDTH - 2;
    localparam int STORE_DEPTH   = MAX_PACKET_SIZE - 1;
    localparam int CW            = $clog2(MAX_PACKET_SIZE);

    // Index of the last payload slot; a word accepted here ends the packet.
    localparam logic [CW-1:0] LIMIT_IDX = CW'(MAX_PACKET_SIZE - 2);

    localparam logic [ADDRESS_SIZE-1:0] LOCAL_ADDR_W = ADDRESS_SIZE'(LOCAL_ADDR);

    localparam logic [1:0] TYPE_HEADER = `FLIT_HEADER;
    localparam logic [1:0] TYPE_BODY   = `FLIT_BODY;
    localparam logic [1:0] TYPE_TAIL   = `FLIT_TAIL;

    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_HANDOFF = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]               r_state;
    logic [CW-1:0]            r_wordCount;
    logic [CW-1:0]            r_rdPtr;
    logic [ADDRESS_SIZE-1:0]  r_dest;
    logic [PAYLOAD_WIDTH-1:0] r_store [STORE_DEPTH];

    logic                     w_accept;
    logic                     w_atLimit;
    logic                     w_endOfPacket;
    logic                     w_isTail;
    logic [DATA_WIDTH-1:0]    w_header;

    // Word acceptance and end-of-packet detection while collecting.
    // Reaching the last store slot ends the packet even without i_src_last.
    always_comb begin
        w_accept      = i_src_valid && (r_state == ST_COLLECT);
        w_atLimit     = (r_wordCount == LIMIT_IDX);
        w_endOfPacket = w_accept && (i_src_last || w_atLimit);
        w_isTail      = (r_rdPtr == (r_wordCount - CW'(1)));
    end

    // Header flit: type, zero pad, source address, destination address.
    always_comb begin
        w_header                                 = '0;
        w_header[DATA_WIDTH-1:DATA_WIDTH-2]      = TYPE_HEADER;
        w_header[2*ADDRESS_SIZE-1:ADDRESS_SIZE]  = LOCAL_ADDR_W;
        w_header[ADDRESS_SIZE-1:0]               = r_dest;
    end

    // Payload store. No reset: contents are only read back up to the word
    // count of the packet currently held, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_store[r_wordCount] <= i_src_data;
        end
    end

    // Control state machine, word counter, read pointer and latched
    // destination. A reset mid-packet drops everything and returns to
    // collecting, so no further flits of the aborted packet appear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_wordCount <= '0;
            r_rdPtr     <= '0;
            r_dest      <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_wordCount <= r_wordCount + CW'(1);
                        if (r_wordCount == '0) begin
                            r_dest <= i_src_dest;
                        end
                        if (w_endOfPacket) begin
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_tx_ack) begin
                        r_state <= ST_HANDOFF;
                    end
                end
                ST_HANDOFF: begin
                    // The first ack-low cycle carries the header; the
                    // body/tail burst starts on the very next cycle.
                    if (!i_tx_ack) begin
                        r_rdPtr <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_rdPtr <= r_rdPtr + CW'(1);
                    if (w_isTail) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_wordCount <= '0;
                    r_rdPtr     <= '0;
                    r_state     <= ST_COLLECT;
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

    // Outputs are decoded from state so that a reset forces them to their
    // idle values immediately, without waiting for a clock edge.
    always_comb begin
        o_src_ready = 1'b0;
        o_tx_req    = 1'b0;
        o_tx_data   = '0;
        o_pkt_sent  = 1'b0;
        o_truncated = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                o_src_ready = 1'b1;
                o_truncated = w_accept && w_atLimit && !i_src_last;
            end
            ST_REQ: begin
                o_tx_req  = 1'b1;
                o_tx_data = w_header;
            end
            ST_HANDOFF: begin
                o_tx_data = w_header;
            end
            ST_SEND: begin
                o_tx_data = {(w_isTail ? TYPE_TAIL : TYPE_BODY), r_store[r_rdPtr]};
            end
            ST_DONE: begin
                o_pkt_sent = 1'b1;
            end
            default: begin
                o_src_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// ---------------------------------------------------------------------------
// tb_noc_packet_injector
//
// Self-checking bench for noc_packet_injector. Expected flits are pushed to
// a scoreboard queue as payload words are accepted; the receiver side
// captures the flit burst and each scenario task compares the two.
// ---------------------------------------------------------------------------
module tb_noc_packet_injector;

    localparam int DW    = 18;
    localparam int MAXP  = 64;
    localparam int AW    = 4;
    localparam int LOCAL = 2;

    localparam logic [1:0] FT_HEADER = 2'b01;
    localparam logic [1:0] FT_BODY   = 2'b10;
    localparam logic [1:0] FT_TAIL   = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_valid;
    logic          src_ready;
    logic [15:0]   src_data;
    logic          src_last;
    logic [AW-1:0] src_dest;
    logic          tx_req;
    logic          tx_ack;
    logic [DW-1:0] tx_data;
    logic          pkt_sent;
    logic          truncated;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] expQ[$];
    logic [DW-1:0] obsFlits[$];
    logic [15:0]   stimWords[$];

    int   acceptedCount;
    int   truncCount;
    int   truncAt;
    bit   obsReqSeen;
    logic obsPktSent;
    int   obsReadyHigh;

    noc_packet_injector #(
        .DATA_WIDTH      (DW),
        .MAX_PACKET_SIZE (MAXP),
        .ADDRESS_SIZE    (AW),
        .LOCAL_ADDR      (LOCAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_src_valid (src_valid),
        .o_src_ready (src_ready),
        .i_src_data  (src_data),
        .i_src_last  (src_last),
        .i_src_dest  (src_dest),
        .o_tx_req    (tx_req),
        .i_tx_ack    (tx_ack),
        .o_tx_data   (tx_data),
        .o_pkt_sent  (pkt_sent),
        .o_truncated (truncated)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] makeHeader(input logic [AW-1:0] dest);
        logic [3:0] la;
        la = 4'(LOCAL);
        return {FT_HEADER, 8'h00, la, dest};
    endfunction

    // Streams stimWords as a packet, pushing the expected flits for every
    // word the DUT actually accepts.
    task automatic feedWords(input logic [AW-1:0] destFirst, input logic [AW-1:0] destOther,
                             input bit setLast);
        acceptedCount = 0;
        truncCount    = 0;
        truncAt       = -1;
        foreach (stimWords[i]) begin
            src_valid = 1'b1;
            src_data  = stimWords[i];
            src_last  = setLast && (i == stimWords.size() - 1);
            src_dest  = (i == 0) ? destFirst : destOther;
            @(negedge clk);
            if (truncated) begin
                truncCount++;
                truncAt = acceptedCount;
            end
            if (src_ready) begin
                if (acceptedCount == 0) expQ.push_back(makeHeader(destFirst));
                expQ.push_back({((src_last || acceptedCount == MAXP - 2) ? FT_TAIL : FT_BODY),
                                stimWords[i]});
                acceptedCount++;
            end
            @(posedge clk);
            #1;
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
    endtask

    // Receiver: waits for tx_req, acks, then captures nCollect flits starting
    // at the first ack-low cycle, optionally followed by the pkt_sent sample.
    task automatic drainFlits(input int ackDelay, input int ackLen, input int nCollect,
                              input bit wantPkt);
        obsFlits.delete();
        obsReqSeen   = 1'b0;
        obsPktSent   = 1'b0;
        obsReadyHigh = 0;
        for (int c = 0; c < 100 && !obsReqSeen; c++) begin
            @(negedge clk);
            if (tx_req) obsReqSeen = 1'b1;
        end
        if (!obsReqSeen) return;
        repeat (ackDelay) @(posedge clk);
        @(posedge clk);
        #1 tx_ack = 1'b1;
        repeat (ackLen) @(posedge clk);
        #1 tx_ack = 1'b0;
        for (int k = 0; k < nCollect; k++) begin
            @(negedge clk);
            obsFlits.push_back(tx_data);
            if (src_ready) obsReadyHigh++;
        end
        if (wantPkt) begin
            @(negedge clk);
            obsPktSent = pkt_sent;
            if (src_ready) obsReadyHigh++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        src_valid = 1'b0;
        src_data  = '0;
        src_last  = 1'b0;
        src_dest  = '0;
        tx_ack    = 1'b0;
        #1;
        checks++; if (src_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_src_ready: got %b expected 1", src_ready); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_req: got %b expected 0", tx_req); end
        checks++; if (tx_data !== '0) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 0", tx_data); end
        checks++; if (pkt_sent !== 1'b0) begin errors++; $display("[TB] FAIL reset_pkt_sent: got %b expected 0", pkt_sent); end
        checks++; if (truncated !== 1'b0) begin errors++; $display("[TB] FAIL reset_truncated: got %b expected 0", truncated); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_packet();
        logic [DW-1:0] exp, got;
        $display("[TB] basic three-word packet");
        stimWords = '{16'hA001, 16'hA002, 16'hA003};
        feedWords(4'd5, 4'd5, 1'b1);
        checks++; if (acceptedCount !== 3) begin errors++; $display("[TB] FAIL basic_accepted: got %0d expected 3", acceptedCount); end
        checks++; if (truncCount !== 0) begin errors++; $display("[TB] FAIL basic_truncated: got %0d expected 0", truncCount); end
        drainFlits(1, 1, expQ.size(), 1'b1);
        checks++; if (obsReqSeen !== 1'b1) begin errors++; $display("[TB] FAIL basic_req: got %b expected 1", obsReqSeen); end
        checks++; if (obsFlits.size() !== expQ.size()) begin errors++; $display("[TB] FAIL basic_flit_count: got %0d expected %0d", obsFlits.size(), expQ.size()); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL basic_flit: got %h expected %h", got, exp); end
        end
        checks++; if (obsPktSent !== 1'b1) begin errors++; $display("[TB] FAIL basic_pkt_sent: got %b expected 1", obsPktSent); end
    endtask

    task automatic test_single_word();
        logic [DW-1:0] exp, got;
        $display("[TB] single-word packet, long ack");
        stimWords = '{16'hBEEF};
        feedWords(4'd9, 4'd9, 1'b1);
        drainFlits(0, 3, expQ.size(), 1'b1);
        checks++; if (obsFlits.size() !== 2) begin errors++; $display("[TB] FAIL single_flit_count: got %0d expected 2", obsFlits.size()); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL single_flit: got %h expected %h", got, exp); end
        end
        checks++; if (obsPktSent !== 1'b1) begin errors++; $display("[TB] FAIL single_pkt_sent: got %b expected 1", obsPktSent); end
    endtask

    task automatic test_truncation();
        logic [DW-1:0] exp, got;
        $display("[TB] truncation at max packet length");
        stimWords.delete();
        for (int i = 0; i < 70; i++) stimWords.push_back(16'h3000 + 16'(i));
        feedWords(4'd3, 4'd3, 1'b0);
        checks++; if (acceptedCount !== MAXP - 1) begin errors++; $display("[TB] FAIL trunc_accepted: got %0d expected %0d", acceptedCount, MAXP - 1); end
        checks++; if (truncCount !== 1) begin errors++; $display("[TB] FAIL trunc_pulses: got %0d expected 1", truncCount); end
        checks++; if (truncAt !== MAXP - 2) begin errors++; $display("[TB] FAIL trunc_position: got %0d expected %0d", truncAt, MAXP - 2); end
        checks++; if (src_ready !== 1'b0) begin errors++; $display("[TB] FAIL trunc_ready_low: got %b expected 0", src_ready); end
        drainFlits(0, 1, expQ.size(), 1'b1);
        checks++; if (obsFlits.size() !== MAXP) begin errors++; $display("[TB] FAIL trunc_flit_count: got %0d expected %0d", obsFlits.size(), MAXP); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL trunc_flit: got %h expected %h", got, exp); end
        end
        checks++; if (obsPktSent !== 1'b1) begin errors++; $display("[TB] FAIL trunc_pkt_sent: got %b expected 1", obsPktSent); end
    endtask

    task automatic test_ack_delay();
        logic [DW-1:0] exp, got, hdr;
        $display("[TB] ack withheld for ten cycles");
        stimWords = '{16'h4001, 16'h4002};
        feedWords(4'd4, 4'd4, 1'b1);
        hdr = makeHeader(4'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (tx_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_tx_req: got %b expected 1", tx_req); end
            checks++; if (tx_data !== hdr) begin errors++; $display("[TB] FAIL wait_tx_data: got %h expected %h", tx_data, hdr); end
            checks++; if (src_ready !== 1'b0) begin errors++; $display("[TB] FAIL wait_src_ready: got %b expected 0", src_ready); end
        end
        drainFlits(0, 1, expQ.size(), 1'b1);
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL delay_flit: got %h expected %h", got, exp); end
        end
        checks++; if (obsPktSent !== 1'b1) begin errors++; $display("[TB] FAIL delay_pkt_sent: got %b expected 1", obsPktSent); end
    endtask

    task automatic test_mid_packet_reset();
        logic [DW-1:0] exp, got;
        $display("[TB] reset during a burst");
        stimWords = '{16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005};
        feedWords(4'd1, 4'd1, 1'b1);
        drainFlits(1, 1, 2, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (tx_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_tx_req: got %b expected 0", tx_req); end
        checks++; if (tx_data !== '0) begin errors++; $display("[TB] FAIL abort_tx_data: got %h expected 0", tx_data); end
        checks++; if (src_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_src_ready: got %b expected 1", src_ready); end
        for (int k = 0; k < 2; k++) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL abort_flit: got %h expected %h", got, exp); end
        end
        expQ.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (tx_data !== '0) begin errors++; $display("[TB] FAIL abort_quiet: got %h expected 0", tx_data); end
        end
        @(posedge clk);
        #1;
        stimWords = '{16'hC001, 16'hC002};
        feedWords(4'd6, 4'd6, 1'b1);
        drainFlits(0, 1, expQ.size(), 1'b1);
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL after_reset_flit: got %h expected %h", got, exp); end
        end
        checks++; if (obsPktSent !== 1'b1) begin errors++; $display("[TB] FAIL after_reset_pkt_sent: got %b expected 1", obsPktSent); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp, got;
        $display("[TB] valid held through transfer, back-to-back packets");
        stimWords = '{16'h6001, 16'h6002, 16'h6003};
        feedWords(4'd3, 4'd7, 1'b1);
        src_valid = 1'b1;
        src_data  = 16'h5555;
        src_last  = 1'b1;
        src_dest  = 4'hC;
        drainFlits(1, 1, expQ.size(), 1'b1);
        checks++; if (obsReadyHigh !== 0) begin errors++; $display("[TB] FAIL hold_ready_leak: got %0d expected 0", obsReadyHigh); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL hold_pkt1_flit: got %h expected %h", got, exp); end
        end
        expQ.push_back(makeHeader(4'hC));
        expQ.push_back({FT_TAIL, 16'h5555});
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        src_last  = 1'b0;
        drainFlits(0, 1, expQ.size(), 1'b1);
        checks++; if (obsFlits.size() !== 2) begin errors++; $display("[TB] FAIL hold_pkt2_count: got %0d expected 2", obsFlits.size()); end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            got = (obsFlits.size() > 0) ? obsFlits.pop_front() : 'x;
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL hold_pkt2_flit: got %h expected %h", got, exp); end
        end
        checks++; if (obsPktSent !== 1'b1) begin errors++; $display("[TB] FAIL hold_pkt2_sent: got %b expected 1", obsPktSent); end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_single_word();
        test_truncation();
        test_ack_delay();
        test_mid_packet_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
